count_sequencer: RTL and testbench

//   Sequencing controller for the free-running up-counter datapath: takes a

---
 rtl/count_sequencer_if.sv | 28 ++
 rtl/count_sequencer.sv | 113 +++++++++++
 tb/tb_count_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Bus bundle between the sequencing controller and whatever drives it.
// Carries configuration, start/stop commands and the count/status outputs.
interface count_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [WIDTH-1:0]   cfg_limit;
  logic [PRESC_W-1:0] cfg_prescale;
  logic               cfg_mode;
  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   count;
  logic               busy;
  logic               wrap;
  logic               done;

  modport master (
    output cfg_valid, cfg_limit, cfg_prescale, cfg_mode, start, stop,
    input  cfg_ready, count, busy, wrap, done
  );

  modport slave (
    input  cfg_valid, cfg_limit, cfg_prescale, cfg_mode, start, stop,
    output cfg_ready, count, busy, wrap, done
  );
endinterface

// File: rtl/count_sequencer.sv
// Programmable, stoppable up-counter sequencer: latches a terminal value,
// prescale and mode, then steps the count on prescaler ticks while running.
module count_sequencer #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  count_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   count_q;
  logic [PRESC_W-1:0] presc_cnt_q;
  logic [WIDTH-1:0]   limit_q;
  logic [PRESC_W-1:0] presc_q;
  logic               mode_q;
  logic               busy_q;
  logic               wrap_q;
  logic               done_q;

  logic cfg_ready;
  logic cfg_xfer;
  logic tick;
  logic at_limit;

  assign cfg_ready = (state_q != S_RUN);
  assign cfg_xfer  = bus.cfg_valid & cfg_ready;
  assign tick      = (presc_cnt_q == presc_q);
  assign at_limit  = (count_q == limit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      presc_cnt_q <= '0;
      limit_q     <= '0;
      presc_q     <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;

      if (cfg_xfer) begin
        limit_q <= bus.cfg_limit;
        presc_q <= bus.cfg_prescale;
        mode_q  <= bus.cfg_mode;
      end

      unique case (state_q)
        S_IDLE: begin
          if (cfg_xfer) begin
            state_q <= S_ARMED;
          end
        end

        S_ARMED: begin
          // stop dominates a simultaneous start
          if (bus.start && !bus.stop) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            count_q     <= '0;
            presc_cnt_q <= '0;
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            state_q     <= S_ARMED;
            busy_q      <= 1'b0;
            presc_cnt_q <= '0;
          end else if (tick) begin
            presc_cnt_q <= '0;
            if (!at_limit) begin
              count_q <= count_q + 1'b1;
            end else if (mode_q) begin
              count_q <= '0;
              wrap_q  <= 1'b1;
            end else begin
              // one-shot: hold at the terminal value and drop back to ARMED
              done_q  <= 1'b1;
              state_q <= S_ARMED;
              busy_q  <= 1'b0;
            end
          end else begin
            presc_cnt_q <= presc_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed, table-driven check of count_sequencer plus hand-written
// sequences for asynchronous reset mid-run and start while unconfigured.
module tb_count_sequencer;

  localparam int WIDTH   = 4;
  localparam int PRESC_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  count_sequencer_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus_if ();

  count_sequencer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic       cfg_valid;
    logic [3:0] lim;
    logic [3:0] presc;
    logic       mode;
    logic       start;
    logic       stop;
    logic [3:0] e_count;
    logic       e_busy;
    logic       e_wrap;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(int v, int lim, int p, int m, int st, int sp,
                              int c, int b, int w, int d, int r);
    vec_t x;
    x.cfg_valid = v[0];
    x.lim       = 4'(lim);
    x.presc     = 4'(p);
    x.mode      = m[0];
    x.start     = st[0];
    x.stop      = sp[0];
    x.e_count   = 4'(c);
    x.e_busy    = b[0];
    x.e_wrap    = w[0];
    x.e_done    = d[0];
    x.e_ready   = r[0];
    vecs.push_back(x);
  endfunction

  function automatic logic [7:0] outs();
    return {bus_if.count, bus_if.busy, bus_if.wrap, bus_if.done, bus_if.cfg_ready};
  endfunction

  task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got {count,busy,wrap,done,ready}=%h required %h",
               name, idx, act, exp);
    end else begin
      $display("%s[%0d]: {count,busy,wrap,done,ready}=%h ok", name, idx, act);
    end
  endtask

  task automatic drive(logic v, logic [3:0] lim, logic [3:0] p, logic m,
                       logic st, logic sp);
    bus_if.cfg_valid    = v;
    bus_if.cfg_limit    = lim;
    bus_if.cfg_prescale = p;
    bus_if.cfg_mode     = m;
    bus_if.start        = st;
    bus_if.stop         = sp;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_hold", 0, outs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    edge_step();
    check("reset_hold", 1, outs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;

    // asynchronous reset in the middle of a run at count=5
    drive(1'b1, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0);
    edge_step();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    edge_step();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) edge_step();
    check("run_to_5", 0, outs(), {4'd5, 1'b1, 1'b0, 1'b0, 1'b0});
    #2 rst = 1'b1;
    #1;
    check("async_rst", 0, outs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    edge_step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("idle_start", i, outs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    end

    // periodic, limit 3, prescale 0 (still IDLE, start ignored first)
    add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1);
    add(1, 3, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, 0, k % 4, 1, (k % 4 == 0), 0, 0);
    add(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1);

    // one-shot, limit 9, prescale 2
    add(1, 9, 2, 0, 0, 0,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    for (int e = 1; e <= 29; e++) add(0, 0, 0, 0, 0, 0, e / 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  9, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,  9, 0, 0, 0, 1);

    // start&stop together stays ARMED; config offered during RUN is ignored
    add(0, 0, 0, 0, 1, 1,  9, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  9, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    for (int e = 1; e <= 29; e++) add((e <= 5), 2, 0, 1, 0, 0, e / 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  9, 0, 0, 1, 1);

    // limit 0, prescale 1, periodic
    add(1, 0, 1, 1, 0, 0,  9, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    for (int e = 1; e <= 8; e++) add(0, 0, 0, 0, 0, 0, 0, 1, (e % 2 == 0), 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);

    // limit 15, prescale 1: stop on the tick edge at count 7, then a full wrap
    add(1, 15, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    for (int e = 1; e <= 15; e++) add(0, 0, 0, 0, 0, 0, e / 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  7, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  7, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    for (int e = 1; e <= 32; e++) add(0, 0, 0, 0, 0, 0, (e / 2) % 16, 1, (e == 32), 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cfg_valid, vecs[i].lim, vecs[i].presc, vecs[i].mode,
            vecs[i].start, vecs[i].stop);
      edge_step();
      check("vec", i, outs(), {vecs[i].e_count, vecs[i].e_busy, vecs[i].e_wrap,
                               vecs[i].e_done, vecs[i].e_ready});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
